// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial add/subtract unit:
// FSM encodings and a counter-width helper.
`timescale 1ns/1ps
package adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Digit counter width: clog2(n), never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_digit.sv
// DIGIT-bit combinational ripple adder built from full-adder equations.
// One instance is reused for every digit of the serial loop.
`timescale 1ns/1ps
module adder_digit #(
  parameter int DIGIT = 2
) (
  input  logic             Cin,
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  output logic             Cout,
  output logic [DIGIT-1:0] S
);

  logic c;

  // Ripple the carry through each full-adder bit
  always_comb begin
    c = Cin;
    S = '0;
    for (int i = 0; i < DIGIT; i++) begin
      S[i] = A[i] ^ B[i] ^ c;
      c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end

endmodule

// File: rtl/adder_serial_addsub.sv
// Digit-serial add/subtract unit: WIDTH-bit operands, DIGIT bits per clock,
// start/busy/done handshake, carry/borrow chain and signed overflow.
`timescale 1ns/1ps
module adder_serial_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Sub,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Cout,
  output logic             V,
  output logic [WIDTH-1:0] S
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("adder_serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_full;
  logic             carry;
  logic [DIGIT-1:0] a_d;
  logic [DIGIT-1:0] b_d;
  logic [DIGIT-1:0] d_s;
  logic             d_c;
  logic             accept;
  logic             last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(N - 1));

  // Select the current digit and merge its sum into the shadow result
  always_comb begin
    a_d    = a_r[cnt*DIGIT +: DIGIT];
    b_d    = b_r[cnt*DIGIT +: DIGIT];
    s_full = s_sh;
    s_full[cnt*DIGIT +: DIGIT] = d_s;
  end

  adder_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .Cin  (carry),
    .A    (a_d),
    .B    (b_d),
    .Cout (d_c),
    .S    (d_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE accepts a new start just like IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand latch, digit loop and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      V     <= 1'b0;
    end else if (accept) begin
      a_r   <= A;
      b_r   <= Sub ? ~B : B;
      carry <= Sub ? ~Cin : Cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      s_sh  <= s_full;
      carry <= d_c;
      if (last) begin
        S    <= s_full;
        Cout <= d_c;
        V    <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                (s_full[WIDTH-1] != a_r[WIDTH-1]);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_serial_addsub.sv
// Scoreboard bench for adder_serial_addsub: directed cases on WIDTH=8/DIGIT=2,
// plus random sweeps on DIGIT=8 and DIGIT=1 against a reference model.
`timescale 1ns/1ps
module tb_adder_serial_addsub;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  logic       start0 = 1'b0, sub0 = 1'b0, cin0 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0;
  logic       busy0, done0, cout0, v0;
  logic [7:0] s0;

  logic       sw_start = 1'b0, sw_sub = 1'b0, sw_cin = 1'b0;
  logic [7:0] sw_a = '0, sw_b = '0;
  logic       busy1, done1, cout1, v1;
  logic [7:0] s1;
  logic       busy2, done2, cout2, v2;
  logic [7:0] s2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_serial_addsub #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .rst(rst), .start(start0), .Sub(sub0), .Cin(cin0),
    .A(a0), .B(b0), .busy(busy0), .done(done0), .Cout(cout0), .V(v0), .S(s0)
  );

  adder_serial_addsub #(.WIDTH(8), .DIGIT(8)) u1 (
    .clk(clk), .rst(rst), .start(sw_start), .Sub(sw_sub), .Cin(sw_cin),
    .A(sw_a), .B(sw_b), .busy(busy1), .done(done1), .Cout(cout1), .V(v1), .S(s1)
  );

  adder_serial_addsub #(.WIDTH(8), .DIGIT(1)) u2 (
    .clk(clk), .rst(rst), .start(sw_start), .Sub(sw_sub), .Cin(sw_cin),
    .A(sw_a), .B(sw_b), .busy(busy2), .done(done2), .Cout(cout2), .V(v2), .S(s2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t ref_op(input logic [7:0] a, input logic [7:0] b,
                                  input logic sub, input logic cin,
                                  input int due);
    exp_t e;
    logic [8:0] full;
    if (sub) begin
      full = {1'b0, a} - {1'b0, b} - {8'd0, cin};
      e.c  = ~full[8];
      e.s  = full[7:0];
      e.v  = (a[7] != b[7]) && (e.s[7] != a[7]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      e.c  = full[8];
      e.s  = full[7:0];
      e.v  = (a[7] == b[7]) && (e.s[7] != a[7]);
    end
    e.due = due;
    return e;
  endfunction

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst && done0) begin
      chk("q0_has_entry", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("s0", s0, e.s);
        chk("cout0", cout0, e.c);
        chk("v0", v0, e.v);
        chk("lat0", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && done1) begin
      chk("q1_has_entry", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("s1", s1, e.s);
        chk("cout1", cout1, e.c);
        chk("v1", v1, e.v);
        chk("lat1", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst && done2) begin
      chk("q2_has_entry", 32'(q2.size() != 0), 1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("s2", s2, e.s);
        chk("cout2", cout2, e.c);
        chk("v2", v2, e.v);
        chk("lat2", cyc, e.due);
      end
    end
  end

  // Call at a negedge; start is sampled at the following posedge
  task automatic drive0(input logic [7:0] a, input logic [7:0] b,
                        input logic sub, input logic cin);
    a0 = a; b0 = b; sub0 = sub; cin0 = cin; start0 = 1'b1;
    q0.push_back(ref_op(a, b, sub, cin, cyc + 1 + 4));
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_q0(input string tag);
    for (int i = 0; i < 40 && q0.size() != 0; i++) @(negedge clk);
    chk(tag, q0.size(), 0);
  endtask

  task automatic op0(input logic [7:0] a, input logic [7:0] b,
                     input logic sub, input logic cin, input string tag);
    @(negedge clk);
    drive0(a, b, sub, cin);
    wait_q0(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy_n;
    logic [7:0] ra, rb;
    logic rs, rc;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_s", s0, 0);
    chk("rst_cout", cout0, 0);
    chk("rst_v", v0, 0);
    rst = 1'b0;

    op0(8'd2,   8'd3,   1'b0, 1'b0, "add_2_3");
    op0(8'd255, 8'd255, 1'b0, 1'b0, "add_ff_ff");
    op0(8'd255, 8'd255, 1'b0, 1'b1, "add_ff_ff_cin");
    op0(8'd5,   8'd3,   1'b1, 1'b0, "sub_5_3");
    op0(8'd3,   8'd5,   1'b1, 1'b0, "sub_3_5");
    op0(8'd5,   8'd3,   1'b1, 1'b1, "sub_5_3_bin");
    op0(8'd127, 8'd1,   1'b0, 1'b0, "ovf_add");
    op0(8'd128, 8'd1,   1'b1, 1'b0, "ovf_sub");

    // start held through RUN; operand changes mid-flight must be ignored
    @(negedge clk);
    a0 = 8'd100; b0 = 8'd27; sub0 = 1'b0; cin0 = 1'b0; start0 = 1'b1;
    q0.push_back(ref_op(8'd100, 8'd27, 1'b0, 1'b0, cyc + 1 + 4));
    busy_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) begin a0 = 8'hff; b0 = 8'hff; sub0 = 1'b1; end
      if (i == 4) start0 = 1'b0;
      busy_n += int'(busy0);
    end
    chk("busy_cycles", busy_n, 4);
    chk("held_start_single", q0.size(), 0);

    // back-to-back: new start in the DONE cycle
    @(negedge clk);
    drive0(8'd200, 8'd50, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !done0; i++) @(negedge clk);
    chk("b2b_first_done", done0, 1);
    drive0(8'd10, 8'd20, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_hold_s", s0, 8'd250);
      @(negedge clk);
    end
    wait_q0("b2b_drain");

    // reset two cycles into RUN
    @(negedge clk);
    drive0(8'd7, 8'd9, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    q0.delete();
    @(negedge clk);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_s", s0, 0);
    chk("mid_rst_cout", cout0, 0);
    chk("mid_rst_v", v0, 0);
    rst = 1'b0;
    op0(8'd1, 8'd1, 1'b0, 1'b0, "after_rst");

    // random sweep on N=1 and N=8 instances
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      @(negedge clk);
      sw_a = ra; sw_b = rb; sw_sub = rs; sw_cin = rc; sw_start = 1'b1;
      q1.push_back(ref_op(ra, rb, rs, rc, cyc + 1 + 1));
      q2.push_back(ref_op(ra, rb, rs, rc, cyc + 1 + 8));
      @(negedge clk);
      sw_start = 1'b0;
      chk("sw_busy1", busy1, 1);
      chk("sw_busy2", busy2, 1);
      for (int j = 0; j < 20 && (q1.size() + q2.size()) != 0; j++)
        @(negedge clk);
      chk("sw_drain", q1.size() + q2.size(), 0);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_serial_addsub.md
Name: adder_serial_addsub

Overview:
- Parametrised, multi-cycle digit-serial add/subtract unit; successor to the combinational 8-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, with a start/busy/done handshake, a carry/borrow chain and a signed-overflow flag.
- Sits in the datapath wherever a narrow, low-area adder is acceptable in exchange for WIDTH/DIGIT cycles of latency.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 2, bits processed per cycle; must divide WIDTH exactly. A static elaboration check fails on violation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE or DONE.
- Sub  input  1  0 = add, 1 = subtract; latched on an accepted start.
- Cin  input  1  carry-in (add) or borrow-in (subtract); latched on an accepted start.
- A  input  WIDTH  operand A; latched on an accepted start.
- B  input  WIDTH  operand B; latched on an accepted start.
- busy  output  1  high while the digit loop is running.
- done  output  1  one-cycle pulse when the result becomes valid.
- Cout  output  1  carry-out of the MSB digit; in subtract mode, 1 means no borrow.
- V  output  1  signed two's-complement overflow.
- S  output  WIDTH  result.

Behaviour:
- Reset (rst=1 at a clock edge) has priority over everything, including mid-operation. It sets state=IDLE, busy=0, done=0, Cout=0, V=0, S=0, and clears internal operand, carry and digit-counter registers.
- Let N = WIDTH/DIGIT.
- Arithmetic:
  - Add: {Cout,S} = A + B + Cin.
  - Subtract: B is inverted and the effective carry-in is ~Cin, so S = A − B − Cin (mod 2^WIDTH) and Cout = ~borrow.
  - V = (a_msb == b_eff_msb) && (S_msb != a_msb), where b_eff is B in add mode and ~B in subtract mode.
- FSM states:
  - IDLE: busy=0. start=1 latches A, Sub, Cin and the effective B; sets carry to the effective carry-in, counter to 0, state to RUN.
  - RUN: busy=1. Each cycle, digit `counter` (bits counter*DIGIT .. counter*DIGIT+DIGIT−1) is added with the stored carry. The sum digit is written into the S shadow register and the carry register is updated. When counter == N−1, go to DONE; otherwise increment counter.
  - DONE: done=1 for exactly this cycle and busy=0. S, Cout and V are updated from the shadow registers on entry to DONE. start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation. Otherwise go to IDLE.
- Latency: start sampled at edge k → done high in the cycle after edge k+N; S/Cout/V are valid from that cycle.
- Output holding: S, Cout and V hold their value until the next DONE or reset. They do not change during RUN.
- start while in RUN is ignored; operands are not re-latched.
- Input changes on A, B, Sub or Cin after acceptance have no effect on the operation in flight.
- Wrap-around: the result is modulo 2^WIDTH. Cout carries the overflow bit. No saturation.
- Degenerate case DIGIT == WIDTH: N = 1, and RUN lasts exactly one cycle.

Decomposition:
- Shared package adder_pkg contains:
  - FSM state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - A helper function computing the counter width, clog2(N) with a minimum of 1.
- One natural sub-module, adder_digit: a combinational DIGIT-bit ripple adder (Cin, A, B → Cout, S) built from full-adder equations and instantiated once inside the digit loop.

Test Plan (all with WIDTH=8, DIGIT=2, so N=4):
- Add, basic: Sub=0, Cin=0, A=2, B=3, start pulse → done 4 cycles later; S=5, Cout=0, V=0. Then A=255, B=255 → S=254, Cout=1, V=0. Then Cin=1 with A=255, B=255 → S=255, Cout=1.
- Subtract: Sub=1, Cin=0, A=5, B=3 → S=2, Cout=1, V=0. Then A=3, B=5 → S=254, Cout=0. Then Cin=1 with A=5, B=3 → S=1, Cout=1.
- Overflow: add A=127, B=1 → S=128, V=1, Cout=0. Subtract A=128, B=1 → S=127, V=1, Cout=1.
- Handshake:
  - start held high throughout RUN → only one operation runs, and busy stays high for exactly 4 cycles.
  - start asserted in the DONE cycle with new operands (A=10, B=20) → second done exactly 4 cycles later with S=30, and the previous S held until then.
- Reset mid-operation: assert rst 2 cycles into RUN → next cycle busy=0, done=0, S=0, Cout=0, V=0. A following start with A=1, B=1 → S=2 after 4 cycles.
- Parameter sweep: DIGIT=8 (N=1) and DIGIT=1 (N=8) with random A, B, Sub, Cin, compared against a behavioural reference model → zero mismatches over 1000 vectors, with latency equal to N in each case.
